// File: rtl/key_pkg.sv
// Shared constants and state encoding for the multi-channel key debouncer.
// Defaults assume a 50 MHz system clock.
package key_pkg;

    localparam int unsigned CNT_MAX_DEF    = 999_999;     // 20 ms
    localparam int unsigned LONG_MAX_DEF   = 49_999_999;  // 1 s
    localparam int unsigned REPEAT_MAX_DEF = 9_999_999;   // 200 ms

    typedef logic [1:0] key_state_t;

    localparam key_state_t RELEASED  = 2'd0;
    localparam key_state_t PRESSED   = 2'd1;
    localparam key_state_t LONG_HELD = 2'd2;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-FF synchroniser, debounce counter, and a hold/repeat
// state machine that emits one-cycle press/release/long/repeat pulses.
module key_filter_ch
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_flag,
    output logic release_flag,
    output logic long_flag,
    output logic repeat_flag
);

    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam int HW = $clog2(LONG_MAX) + 1;
    localparam int RW = $clog2(REPEAT_MAX) + 1;

    logic [1:0]    sync_ff;
    logic          key_sync;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic [RW-1:0] rpt;
    key_state_t    state;
    logic          accept;
    logic          releasing;
    logic          hold_done;
    logic          rpt_done;

    assign key_sync  = sync_ff[1];
    assign accept    = (key_sync != key_level) && (cnt == CW'(CNT_MAX - 1));
    assign releasing = accept && key_sync;
    assign hold_done = (state == PRESSED) && (hold == HW'(LONG_MAX - 1));
    assign rpt_done  = REPEAT_EN && (state == LONG_HELD) && (rpt == RW'(REPEAT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff      <= 2'b11;
            key_level    <= 1'b1;
            cnt          <= '0;
            hold         <= '0;
            rpt          <= '0;
            state        <= RELEASED;
            press_flag   <= 1'b0;
            release_flag <= 1'b0;
            long_flag    <= 1'b0;
            repeat_flag  <= 1'b0;
        end else begin
            sync_ff      <= {sync_ff[0], key_in};
            press_flag   <= accept && !key_sync;
            release_flag <= releasing;
            // An accepted release on the same edge outranks long/repeat.
            long_flag    <= hold_done && !releasing;
            repeat_flag  <= rpt_done && !releasing;

            if (key_sync == key_level || accept)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (accept)
                key_level <= key_sync;

            if (releasing) begin
                state <= RELEASED;
                hold  <= '0;
                rpt   <= '0;
            end else begin
                case (state)
                    RELEASED: begin
                        hold <= '0;
                        rpt  <= '0;
                        if (accept)
                            state <= PRESSED;
                    end
                    PRESSED: begin
                        if (hold_done) begin
                            state <= LONG_HELD;
                            rpt   <= '0;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end
                    LONG_HELD: begin
                        // hold stays put here, so it saturates instead of wrapping
                        if (rpt_done)
                            rpt <= '0;
                        else if (REPEAT_EN)
                            rpt <= rpt + RW'(1);
                    end
                    default: state <= RELEASED;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_key_filter.sv
// N-channel key debouncer: reset synchroniser, one key_filter_ch per key,
// and an OR of all press pulses.
module multi_key_filter
    import key_pkg::*;
#(
    parameter int          KEY_NUM    = 4,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag,
    output logic [KEY_NUM-1:0] repeat_flag,
    output logic               any_press
);

    logic [1:0] rst_ff;
    logic       rst_n;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rst_ff <= 2'b00;
        else
            rst_ff <= {rst_ff[0], 1'b1};
    end

    assign rst_n = rst_ff[1];

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX   (CNT_MAX),
            .LONG_MAX  (LONG_MAX),
            .REPEAT_MAX(REPEAT_MAX),
            .REPEAT_EN (REPEAT_EN)
        ) u_ch (
            .clk         (sys_clk),
            .rst_n       (rst_n),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .press_flag  (press_flag[i]),
            .release_flag(release_flag[i]),
            .long_flag   (long_flag[i]),
            .repeat_flag (repeat_flag[i])
        );
    end

    assign any_press = |press_flag;

endmodule

// File: tb/tb_multi_key_filter.sv
// Randomised and directed stimulus for multi_key_filter, checked every cycle
// against a timestamp-based model plus hand-computed event timings.
module tb_multi_key_filter;

    localparam int KN  = 4;
    localparam int CNT = 24;
    localparam int LNG = 100;
    localparam int REP = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KN-1:0] key_in = '1;
    logic [KN-1:0] key_level, press_flag, release_flag, long_flag, repeat_flag;
    logic          any_press;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    multi_key_filter #(
        .KEY_NUM(KN), .CNT_MAX(CNT), .LONG_MAX(LNG), .REPEAT_MAX(REP), .REPEAT_EN(1'b1)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in),
        .key_level(key_level), .press_flag(press_flag), .release_flag(release_flag),
        .long_flag(long_flag), .repeat_flag(repeat_flag), .any_press(any_press)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
        end
    endtask

    // Model: accept after CNT consecutive edges of a synced level differing from
    // the debounced one; long/repeat from elapsed edges since the press edge.
    logic          m_r1, m_r2;
    int            m_n;
    logic [KN-1:0] m_s1, m_s2, m_lvl, m_pf, m_rf, m_lf, m_rpf;
    int            m_tdiff[KN];
    int            m_tpress[KN];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !m_r2) begin
            m_s1 <= '1; m_s2 <= '1; m_lvl <= '1;
            m_pf <= '0; m_rf <= '0; m_lf <= '0; m_rpf <= '0;
            m_n  <= 0;
            for (int i = 0; i < KN; i++) begin
                m_tdiff[i]  <= 0;
                m_tpress[i] <= 0;
            end
            m_r1 <= rst_n;
            m_r2 <= rst_n ? m_r1 : 1'b0;
        end else begin
            m_n  <= m_n + 1;
            m_s1 <= key_in;
            m_s2 <= m_s1;
            for (int i = 0; i < KN; i++) begin
                automatic logic acc  = (m_s2[i] != m_lvl[i]) && (m_n - m_tdiff[i] + 1 == CNT);
                automatic logic rel  = acc && m_s2[i];
                automatic int   held = m_n - m_tpress[i];
                m_pf[i]  <= acc && !m_s2[i];
                m_rf[i]  <= rel;
                m_lf[i]  <= !m_lvl[i] && !rel && held == LNG;
                m_rpf[i] <= !m_lvl[i] && !rel && held > LNG && ((held - LNG) % REP) == 0;
                if (acc) m_lvl[i] <= m_s2[i];
                if (m_s2[i] == m_lvl[i] || acc) m_tdiff[i] <= m_n + 1;
                if (acc && !m_s2[i]) m_tpress[i] <= m_n;
            end
        end
    end

    // Per-cycle compare plus DUT event log for the directed timing checks.
    int np[KN], nr[KN], nl[KN], nrp[KN], pc[KN], rc[KN], lc[KN], rpc[KN];
    int n1010 = 0;

    initial for (int i = 0; i < KN; i++) begin
        np[i] = 0; nr[i] = 0; nl[i] = 0; nrp[i] = 0;
        pc[i] = 0; rc[i] = 0; lc[i] = 0; rpc[i] = 0;
    end

    always @(negedge clk) begin
        check("key_level", 32'(key_level), 32'(m_lvl));
        check("press_flag", 32'(press_flag), 32'(m_pf));
        check("release_flag", 32'(release_flag), 32'(m_rf));
        check("long_flag", 32'(long_flag), 32'(m_lf));
        check("repeat_flag", 32'(repeat_flag), 32'(m_rpf));
        check("any_press", 32'(any_press), 32'(|m_pf));
        for (int i = 0; i < KN; i++) begin
            if (press_flag[i])   begin np[i]  <= np[i] + 1;  pc[i]  <= cyc; end
            if (release_flag[i]) begin nr[i]  <= nr[i] + 1;  rc[i]  <= cyc; end
            if (long_flag[i])    begin nl[i]  <= nl[i] + 1;  lc[i]  <= cyc; end
            if (repeat_flag[i])  begin nrp[i] <= nrp[i] + 1; rpc[i] <= cyc; end
        end
        if (press_flag == 4'b1010 && any_press) n1010 <= n1010 + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic bounce(input int idx, input logic start);
        int   left;
        int   r;
        logic v;
        left = 60;
        v    = start;
        while (left > 0) begin
            v = ~v;
            r = $urandom_range(1, 20);
            key_in[idx] = v;
            tick(r);
            left -= r;
        end
    endtask

    int base, base2, t_edge, t_press, evsum;

    initial begin
        // 1: reset and idle
        #40 rst_n = 1'b1;
        tick(500);
        check("idle_level", 32'(key_level), 32'hF);
        evsum = 0;
        for (int i = 0; i < KN; i++) evsum += np[i] + nr[i] + nl[i] + nrp[i];
        check("idle_events", evsum, 0);

        // 2: ch0 bounce then hold, bounce then release
        base = np[0];
        bounce(0, 1'b1);
        key_in[0] = 1'b1; tick(1);
        key_in[0] = 1'b0; t_edge = cyc;
        tick(40);
        check("press0_count", np[0] - base, 1);
        check("press0_latency", pc[0] - t_edge, 26);
        base = nr[0];
        bounce(0, 1'b0);
        key_in[0] = 1'b0; tick(1);
        key_in[0] = 1'b1; t_edge = cyc;
        tick(40);
        check("release0_count", nr[0] - base, 1);
        check("release0_latency", rc[0] - t_edge, 26);

        // 3: ch1 short pulse rejected, exact-length pulse accepted
        base = np[1];
        key_in[1] = 1'b0; tick(23);
        key_in[1] = 1'b1; tick(40);
        check("ch1_short_reject", np[1] - base, 0);
        key_in[1] = 1'b0; tick(24);
        key_in[1] = 1'b1; tick(40);
        check("ch1_exact_accept", np[1] - base, 1);

        // 4: ch2 long press with auto-repeat
        base = nl[2]; base2 = nrp[2];
        key_in[2] = 1'b0; tick(27);
        check("ch2_press", np[2], 1);
        t_press = pc[2];
        tick(t_press + 400 - cyc);
        check("ch2_long_count", nl[2] - base, 1);
        check("ch2_long_time", lc[2] - t_press, 100);
        check("ch2_repeat_count", nrp[2] - base2, 7);
        check("ch2_last_repeat", rpc[2] - t_press, 380);
        key_in[2] = 1'b1; tick(40);
        check("ch2_released", nr[2], 1);
        base = nl[2]; base2 = nrp[2];
        tick(200);
        check("ch2_no_long_after", nl[2] - base, 0);
        check("ch2_no_rep_after", nrp[2] - base2, 0);

        // 5: simultaneous press on ch1 and ch3
        base = n1010;
        key_in = key_in & 4'b0101; tick(30);
        check("dual_press", n1010 - base, 1);
        key_in = 4'hF; tick(40);

        // 6: reset mid-count discards progress
        base = np[0];
        key_in[0] = 1'b0; tick(22);
        rst_n = 1'b0; key_in[0] = 1'b1; tick(2);
        rst_n = 1'b1; tick(60);
        check("reset_no_press", np[0] - base, 0);
        check("reset_level", 32'(key_level), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
